// File: rtl/iter_mul_acc_if.sv
// Request/result bundle between the execute stage and the iterative
// multiply / multiply-accumulate unit.
interface iter_mul_acc_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 annul_i;
  logic                 signed_i;
  logic [1:0]           mode_i;
  logic [WIDTH-1:0]     op1_i;
  logic [WIDTH-1:0]     op2_i;
  logic [2*WIDTH-1:0]   acc_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;

  modport master (
    output start_i, annul_i, signed_i, mode_i, op1_i, op2_i, acc_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, mode_i, op1_i, op2_i, acc_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/iter_mul_acc.sv
// Iterative multiplier / multiply-accumulator retiring STEP multiplier bits
// per cycle. Operands are converted to magnitudes at acceptance, multiplied
// unsigned, sign-fixed, then optionally added to / subtracted from the
// latched accumulator. All operands are captured at acceptance, so the
// requester may change its inputs while the unit works.
module iter_mul_acc #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic           clk,
  input logic           rst,
  iter_mul_acc_if.slave bus
);
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {IDLE, RUN, FIX, ACC, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   acc;
  logic [1:0]           mode;
  logic                 neg;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   final_value;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 busy;

  // Unsigned magnitude of an operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic            sg);
    if (sg && v[WIDTH-1]) begin
      magnitude = ~v + WIDTH'(1);
    end else begin
      magnitude = v;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; annul aborts any in-flight operation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) state_next = RUN;
        else                             state_next = IDLE;
      end
      RUN: begin
        if (bus.annul_i)      state_next = IDLE;
        else if (cnt == LAST) state_next = FIX;
        else                  state_next = RUN;
      end
      FIX: begin
        if (bus.annul_i) state_next = IDLE;
        else             state_next = ACC;
      end
      ACC: begin
        if (bus.annul_i) state_next = IDLE;
        else             state_next = DONE;
      end
      DONE: begin
        if (!bus.start_i || bus.annul_i) state_next = IDLE;
        else                             state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial product of the STEP low multiplier bits for this cycle.
  always_comb begin
    partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
      else           partial = partial;
    end
  end

  // Accumulate stage result: plain product, acc + p or acc - p.
  always_comb begin
    final_value = product;
    case (mode)
      2'b01:   final_value = acc + product;
      2'b10:   final_value = acc - product;
      default: final_value = product;
    endcase
  end

  // Datapath: latch operands at acceptance, shift-add in RUN, sign fix in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      acc     <= '0;
      mode    <= 2'b00;
      neg     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_next == RUN) begin
            mcand   <= {{WIDTH{1'b0}}, magnitude(bus.op1_i, bus.signed_i)};
            mplier  <= magnitude(bus.op2_i, bus.signed_i);
            neg     <= bus.signed_i & (bus.op1_i[WIDTH-1] ^ bus.op2_i[WIDTH-1]);
            mode    <= bus.mode_i;
            acc     <= bus.acc_i;
            product <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          product <= product + partial;
          mcand   <= mcand << STEP;
          mplier  <= mplier >> STEP;
          cnt     <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (neg) product <= ~product + (2*WIDTH)'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs; result is only non-zero while ready is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      busy  <= (state_next == RUN) || (state_next == FIX) || (state_next == ACC);
      ready <= (state_next == DONE);
      case (state)
        ACC:     result <= (state_next == DONE) ? final_value : '0;
        DONE:    result <= (state_next == DONE) ? result : '0;
        default: result <= '0;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = busy;
endmodule

// File: tb/tb_iter_mul_acc.sv
// Directed bench for iter_mul_acc: a STEP=1 and a STEP=4 instance share the
// same request inputs and have separate resets.
module tb_iter_mul_acc;
  logic        clk = 1'b0;
  logic        rst1 = 1'b1;
  logic        rst4 = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic        sgn = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] op1 = 32'h0;
  logic [31:0] op2 = 32'h0;
  logic [63:0] acc = 64'h0;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          lat1, lat4;
  logic [63:0] res1, res4;

  iter_mul_acc_if #(.WIDTH(32)) bus1();
  iter_mul_acc_if #(.WIDTH(32)) bus4();

  assign bus1.start_i = start;  assign bus4.start_i = start;
  assign bus1.annul_i = annul;  assign bus4.annul_i = annul;
  assign bus1.signed_i = sgn;   assign bus4.signed_i = sgn;
  assign bus1.mode_i = mode;    assign bus4.mode_i = mode;
  assign bus1.op1_i = op1;      assign bus4.op1_i = op1;
  assign bus1.op2_i = op2;      assign bus4.op2_i = op2;
  assign bus1.acc_i = acc;      assign bus4.acc_i = acc;

  iter_mul_acc #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  iter_mul_acc #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for ready on both instances.
  task automatic run_op(input logic s, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] c, input bit scramble);
    sgn = s; mode = m; op1 = a; op2 = b; acc = c; annul = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat1 = -1; lat4 = -1; res1 = 64'h0; res4 = 64'h0;
    for (int k = 1; k <= 60 && (lat1 < 0 || lat4 < 0); k++) begin
      if (scramble) begin
        op1 = $urandom; op2 = $urandom; acc = {$urandom, $urandom};
        mode = 2'($urandom); sgn = 1'($urandom);
        start = (k < 6) ? 1'($urandom) : 1'b1;
      end
      @(posedge clk); #1;
      if (lat1 < 0 && bus1.ready_o) begin lat1 = k; res1 = bus1.result_o; end
      if (lat4 < 0 && bus4.ready_o) begin lat4 = k; res4 = bus4.result_o; end
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus1.result_o !== 64'h0) $display("FAIL reset_result1 got %h want 0", bus1.result_o); else pass_cnt++;
    total_cnt++; if (bus1.ready_o !== 1'b0) $display("FAIL reset_ready1 got %b want 0", bus1.ready_o); else pass_cnt++;
    total_cnt++; if (bus1.busy_o !== 1'b0) $display("FAIL reset_busy1 got %b want 0", bus1.busy_o); else pass_cnt++;
    total_cnt++; if (bus4.result_o !== 64'h0) $display("FAIL reset_result4 got %h want 0", bus4.result_o); else pass_cnt++;
    total_cnt++; if (bus4.ready_o !== 1'b0) $display("FAIL reset_ready4 got %b want 0", bus4.ready_o); else pass_cnt++;
    total_cnt++; if (bus4.busy_o !== 1'b0) $display("FAIL reset_busy4 got %b want 0", bus4.busy_o); else pass_cnt++;
    rst1 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency_mul();
    run_op(1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0);
    total_cnt++; if (res1 !== 64'hFFFFFFFE00000001) $display("FAIL umax_result1 got %h want fffffffe00000001", res1); else pass_cnt++;
    total_cnt++; if (lat1 !== 34) $display("FAIL latency_step1 got %0d want 34", lat1); else pass_cnt++;
    total_cnt++; if (res4 !== 64'hFFFFFFFE00000001) $display("FAIL umax_result4 got %h want fffffffe00000001", res4); else pass_cnt++;
    total_cnt++; if (lat4 !== 10) $display("FAIL latency_step4 got %0d want 10", lat4); else pass_cnt++;
    release_start();
  endtask

  task automatic test_signed_mul();
    logic [31:0] va [4] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vb [4] = '{32'h00000005, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    logic        vs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] ve [4] = '{64'hFFFFFFFFFFFFFFF1, 64'h4000000000000000,
                            64'h0000000100000000, 64'hFFFFFFFF80000001};
    for (int i = 0; i < 4; i++) begin
      run_op(vs[i], 2'b00, va[i], vb[i], 64'h0, 1'b0);
      total_cnt++; if (res1 !== ve[i]) $display("FAIL mul%0d_step1 got %h want %h", i, res1, ve[i]); else pass_cnt++;
      total_cnt++; if (res4 !== ve[i]) $display("FAIL mul%0d_step4 got %h want %h", i, res4, ve[i]); else pass_cnt++;
      release_start();
    end
  endtask

  task automatic test_madd_msub();
    logic [1:0]  vm [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic        vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] va [4] = '{32'd2, 32'd1, 32'd3, 32'd7};
    logic [31:0] vb [4] = '{32'd3, 32'd1, 32'd5, 32'd6};
    logic [63:0] vc [4] = '{64'h0000000100000000, 64'h0, 64'h100, 64'h100};
    logic [63:0] ve [4] = '{64'h0000000100000006, 64'hFFFFFFFFFFFFFFFF, 64'hF1, 64'h2A};
    for (int i = 0; i < 4; i++) begin
      run_op(vs[i], vm[i], va[i], vb[i], vc[i], 1'b0);
      total_cnt++; if (res1 !== ve[i]) $display("FAIL macc%0d_step1 got %h want %h", i, res1, ve[i]); else pass_cnt++;
      total_cnt++; if (res4 !== ve[i]) $display("FAIL macc%0d_step4 got %h want %h", i, res4, ve[i]); else pass_cnt++;
      release_start();
    end
  endtask

  task automatic test_input_change();
    // signed MADD: 0x10 + (-2 * 7) = 2; inputs and start churn while busy
    run_op(1'b1, 2'b01, 32'hFFFFFFFE, 32'd7, 64'h10, 1'b1);
    total_cnt++; if (res1 !== 64'h2) $display("FAIL latched_result1 got %h want 2", res1); else pass_cnt++;
    total_cnt++; if (lat1 !== 34) $display("FAIL latched_latency1 got %0d want 34", lat1); else pass_cnt++;
    total_cnt++; if (res4 !== 64'h2) $display("FAIL latched_result4 got %h want 2", res4); else pass_cnt++;
    total_cnt++; if (lat4 !== 10) $display("FAIL latched_latency4 got %0d want 10", lat4); else pass_cnt++;
    release_start();
  endtask

  task automatic test_annul();
    bit bad = 1'b0;
    sgn = 1'b0; mode = 2'b00; op1 = 32'd6; op2 = 32'd6; acc = 64'h0; start = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++; if (bus1.busy_o !== 1'b1) $display("FAIL annul_busy_before1 got %b want 1", bus1.busy_o); else pass_cnt++;
    total_cnt++; if (bus4.busy_o !== 1'b1) $display("FAIL annul_busy_before4 got %b want 1", bus4.busy_o); else pass_cnt++;
    annul = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (bus1.busy_o !== 1'b0) $display("FAIL annul_busy_after1 got %b want 0", bus1.busy_o); else pass_cnt++;
    total_cnt++; if (bus4.busy_o !== 1'b0) $display("FAIL annul_busy_after4 got %b want 0", bus4.busy_o); else pass_cnt++;
    annul = 1'b0; start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus1.ready_o !== 1'b0 || bus1.result_o !== 64'h0 ||
          bus4.ready_o !== 1'b0 || bus4.result_o !== 64'h0) bad = 1'b1;
      @(posedge clk); #1;
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL annul_quiet got %b want 0", bad); else pass_cnt++;
    run_op(1'b0, 2'b00, 32'd9, 32'd9, 64'h0, 1'b0);
    total_cnt++; if (res1 !== 64'd81) $display("FAIL post_annul_result1 got %h want 51", res1); else pass_cnt++;
    total_cnt++; if (lat1 !== 34) $display("FAIL post_annul_latency1 got %0d want 34", lat1); else pass_cnt++;
    total_cnt++; if (res4 !== 64'd81) $display("FAIL post_annul_result4 got %h want 51", res4); else pass_cnt++;
    total_cnt++; if (lat4 !== 10) $display("FAIL post_annul_latency4 got %0d want 10", lat4); else pass_cnt++;
    release_start();
  endtask

  task automatic test_handshake();
    bit bad1 = 1'b0;
    bit bad4 = 1'b0;
    run_op(1'b0, 2'b00, 32'd5, 32'd5, 64'h0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus1.ready_o !== 1'b1 || bus1.result_o !== 64'd25 || bus1.busy_o !== 1'b0) bad1 = 1'b1;
      if (bus4.ready_o !== 1'b1 || bus4.result_o !== 64'd25 || bus4.busy_o !== 1'b0) bad4 = 1'b1;
    end
    total_cnt++; if (bad1 !== 1'b0) $display("FAIL hold_step1 got %b want 0", bad1); else pass_cnt++;
    total_cnt++; if (bad4 !== 1'b0) $display("FAIL hold_step4 got %b want 0", bad4); else pass_cnt++;
    release_start();
    total_cnt++; if ({bus1.ready_o, bus1.result_o} !== 65'h0) $display("FAIL drop_step1 got %b/%h want 0/0", bus1.ready_o, bus1.result_o); else pass_cnt++;
    total_cnt++; if ({bus4.ready_o, bus4.result_o} !== 65'h0) $display("FAIL drop_step4 got %b/%h want 0/0", bus4.ready_o, bus4.result_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    sgn = 1'b0; mode = 2'b00; op1 = 32'd4; op2 = 32'd4; acc = 64'h0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (k == 9) begin rst4 = 1'b1; start = 1'b0; end
      if (k == 10) begin
        total_cnt++;
        if ({bus4.ready_o, bus4.busy_o, bus4.result_o} !== 66'h0)
          $display("FAIL rst_acc_step4 got %b/%b/%h want 0/0/0", bus4.ready_o, bus4.busy_o, bus4.result_o);
        else pass_cnt++;
        rst4 = 1'b0;
      end
      if (k == 32) rst1 = 1'b1;
      if (k == 33) begin
        total_cnt++;
        if ({bus1.ready_o, bus1.busy_o, bus1.result_o} !== 66'h0)
          $display("FAIL rst_fix_step1 got %b/%b/%h want 0/0/0", bus1.ready_o, bus1.busy_o, bus1.result_o);
        else pass_cnt++;
        rst1 = 1'b0;
      end
    end
    run_op(1'b0, 2'b00, 32'd11, 32'd13, 64'h0, 1'b0);
    total_cnt++; if (res1 !== 64'd143) $display("FAIL post_rst_result1 got %h want 8f", res1); else pass_cnt++;
    total_cnt++; if (lat1 !== 34) $display("FAIL post_rst_latency1 got %0d want 34", lat1); else pass_cnt++;
    total_cnt++; if (res4 !== 64'd143) $display("FAIL post_rst_result4 got %h want 8f", res4); else pass_cnt++;
    total_cnt++; if (lat4 !== 10) $display("FAIL post_rst_latency4 got %0d want 10", lat4); else pass_cnt++;
    release_start();
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_latency_mul();
    test_signed_mul();
    test_madd_msub();
    test_input_change();
    test_annul();
    test_handshake();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/iter_mul_acc.md
# iter_mul_acc

Parametrised iterative multiply / multiply-accumulate unit for the CPU execute stage. It is the successor to the 1-bit-per-cycle multiplier and serves MULT/MULTU/MADD/MADDU/MSUB/MSUBU. Operand width and bits retired per cycle are set by parameters. All operands, mode and accumulator are latched at start, so the issuing stage may change its inputs while the unit is busy. It uses the same start/annul/ready handshake as the existing multiplier and divider.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- STEP, 1, multiplier bits retired per RUN cycle. Legal values are 1, 2, 4 and 8, and STEP must divide WIDTH. N = WIDTH/STEP.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request. Level-held by the requester until it has consumed the result.
- annul_i  in  1  cancel the current operation (pipeline flush).
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- mode_i  in  2  00 MUL, 01 MADD (acc + p), 10 MSUB (acc − p), 11 treated as MUL.
- op1_i  in  WIDTH  multiplicand.
- op2_i  in  WIDTH  multiplier.
- acc_i  in  2*WIDTH  accumulator ({HI,LO}); used only in MADD/MSUB.
- result_o  out  2*WIDTH  final result; valid while ready_o=1, otherwise 0.
- ready_o  out  1  result valid.
- busy_o  out  1  1 in RUN, FIX and ACC.

## Operation
- States: IDLE, RUN, FIX, ACC, DONE. Reset gives IDLE with result_o=0, ready_o=0, busy_o=0, and the internal counter and registers cleared.
- **IDLE:**
  - If start_i=1 and annul_i=0: latch the following, clear the product accumulator and counter, then go to RUN.
    - |op1| and |op2| as WIDTH-bit unsigned magnitudes (negate only if signed_i and the MSB is set; the most negative value negates to 2^(WIDTH−1), which fits).
    - neg = signed_i & (op1 MSB ^ op2 MSB).
    - mode_i and acc_i.
  - Otherwise stay in IDLE with outputs 0.
- **RUN** (exactly N cycles):
  - product += Σ_{j<STEP} (mplier[j] ? mcand<<j : 0), where mcand is 2*WIDTH wide.
  - Then mcand <<= STEP, mplier >>= STEP, cnt++.
  - When cnt reaches N−1 on that edge, go to FIX.
- **FIX** (1 cycle): if neg, product = ~product + 1; go to ACC.
- **ACC** (1 cycle):
  - result_o is loaded with product (MUL/11), acc+product (MADD) or acc−product (MSUB), all mod 2^(2*WIDTH) with no overflow flag.
  - ready_o goes to 1; go to DONE.
- **DONE:**
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0 or annul_i=1: go to IDLE, with result_o=0 and ready_o=0 on that edge.
- **annul_i=1 in RUN/FIX/ACC:** go to IDLE next edge. ready_o is never asserted for that operation, and result_o stays 0.
- **start_i while busy or in DONE:** ignored; there is no queuing. A new operation requires the IDLE state.
- **rst mid-operation:** overrides everything and gives IDLE with all outputs 0.
- **start_i and annul_i both 1 in IDLE:** not accepted.

## Timing
- The acceptance edge is the edge where IDLE sees start_i=1 and annul_i=0.
- ready_o rises N+2 edges after the acceptance edge: N RUN edges, then FIX, then ACC. Examples:
  - WIDTH=32, STEP=1: 34 cycles.
  - STEP=2: 18 cycles.
  - STEP=4: 10 cycles.
- busy_o is 1 from the edge after acceptance until the ACC edge inclusive, then falls with ready_o rising.
- Back-to-back throughput: drop start_i (1 cycle in DONE→IDLE), then reassert. The minimum spacing between acceptances is N+4 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Latency and basic MUL, STEP=1: unsigned 0xFFFFFFFF × 0xFFFFFFFF → result_o=0xFFFFFFFE00000001 with ready_o at exactly cycle 34. Repeat with STEP=4: same value, at cycle 10.
- Signed MUL: −3 × 5 → 0xFFFFFFFFFFFFFFF1. Signed 0x80000000 × 0x80000000 → 0x4000000000000000. Unsigned 0x80000000 × 2 → 0x0000000100000000.
- MADD/MSUB:
  - MADD, acc=0x0000000100000000, 2×3 → 0x0000000100000006.
  - Signed MSUB, acc=0, 1×1 → 0xFFFFFFFFFFFFFFFF.
  - Change op1_i, op2_i, acc_i and mode_i every cycle after acceptance → the result is unchanged.
- Annul: pulse annul_i in RUN cycle 5 → busy_o falls next edge, ready_o never rises, and result_o stays 0. An immediate new start then produces a correct result.
- Handshake:
  - Hold start_i 20 cycles past ready → result held and no restart.
  - Drop start_i → ready_o and result_o are 0 on the next edge.
  - Start pulses while busy are ignored.
- Reset: assert rst in FIX or ACC → all outputs 0 next edge, and the next operation completes with correct latency and value.
